if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF: instruction word that stops fetch.
REQ-003 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port imemAddr, output, 32: current PC, driven to the combinational instruction memory.
REQ-006 SHALL have port imemData, input, 32: instruction word at imemAddr, valid in the same cycle.
REQ-007 SHALL have port stall, input, 1: load-use hazard; hold PC and IF/ID.
REQ-008 SHALL have port redirect, input, 1: branch taken or jump resolved in ID.
REQ-009 SHALL have port redirectTarget, input, 32: next PC when redirect=1.
REQ-010 SHALL have port instrOut, output, 32: registered instruction; bits [15:0] feed the sign extender.
REQ-011 SHALL have port pcPlus4Out, output, 32: registered PC+4 of instrOut.
REQ-012 SHALL have port validOut, output, 1: instrOut is a real instruction, not a bubble.
REQ-013 SHALL have port halted, output, 1: fetch stopped on HALT_WORD.

Function
REQ-014 SHALL implement FSM states BOOT, RUN and HALT; reset enters BOOT.
REQ-015 In BOOT, SHALL keep PC at RESET_PC and load a bubble, then move to RUN on the next edge.
REQ-016 In RUN, with no stall and no redirect, SHALL load PC<=PC+4, instrOut<=imemData, pcPlus4Out<=PC+4 and validOut<=1 each edge.
REQ-017 SHALL define a bubble as instrOut=32'h0000_0000 (sll $0 nop) with validOut=0; pcPlus4Out is held.
REQ-018 On stall=1 and redirect=0, SHALL hold PC, instrOut, pcPlus4Out and validOut unchanged.
REQ-019 On redirect=1, SHALL load PC<=redirectTarget and a bubble, regardless of stall; redirect has priority.
REQ-020 If redirect=1 in HALT, SHALL take the redirect and return to RUN.
REQ-021 If imemData==HALT_WORD in RUN with no stall and no redirect, SHALL load a bubble, hold PC and enter HALT.
REQ-022 In HALT, SHALL drive halted=1, hold PC and load bubbles until reset or redirect.
REQ-023 PC+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC+4 gives 0 with no error.
REQ-024 PC bits [1:0] SHALL always be 0; redirectTarget[1:0] SHALL be forced to 0 on load.
REQ-025 imemAddr SHALL equal the PC register combinationally, with no added latency.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately set PC=RESET_PC, instrOut=0, pcPlus4Out=0, validOut=0, halted=0 and FSM=BOOT, even mid-stall or mid-redirect.
REQ-027 After rst_n deasserts, the first valid instruction (at RESET_PC) SHALL appear on the second rising edge.

Configuration
REQ-028 With FETCH_STATS_EN defined, SHALL add outputs fetchCount[31:0] and bubbleCount[31:0], both reset to 0.
REQ-029 fetchCount SHALL count edges that load a valid instruction; bubbleCount SHALL count edges that load a bubble; both wrap at 2^32.
REQ-030 Without FETCH_STATS_EN, these ports, counters and their logic SHALL be absent, with all other behaviour identical.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef (BOOT/RUN/HALT), the NOP_WORD constant and the PC width constant, for reuse by the ID/EX stage and hazard unit.
REQ-032 Sub-module fetch_stats SHALL contain the counters, instantiated only under FETCH_STATS_EN; PC, FSM and the IF/ID register stay in if_id_stage.

Verification
REQ-033 Reset release, memory word[i]=i+1 -> edge 1: validOut=0; edge 2: instrOut=1, pcPlus4Out=4, validOut=1; edge 3: instrOut=2, pcPlus4Out=8.
REQ-034 stall=1 for 3 cycles at PC=8 -> imemAddr stays 8; instrOut/validOut unchanged; after release, fetch resumes at 8.
REQ-035 stall=1 and redirect=1 with redirectTarget=32'h40 together -> next edge: imemAddr=32'h40, validOut=0; following edge: valid instruction from 32'h40.
REQ-036 HALT_WORD at address 32'h10 -> halted=1, imemAddr stays 32'h10, bubbles thereafter; redirect to 0 -> halted=0, fetch restarts at 0.
REQ-037 RESET_PC=32'hFFFF_FFFC -> pcPlus4Out=0 and next imemAddr=0; rst_n pulsed low mid-stall -> outputs zero immediately, PC=RESET_PC.
REQ-038 With FETCH_STATS_EN: 5 valid fetches then 1 redirect -> fetchCount=5, bubbleCount=2 (BOOT bubble plus redirect bubble).

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared fetch-stage types and constants
// Reused by the ID/EX stage and hazard unit.
package if_id_stage_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_stage_fetch_stats.sv
// rtl/if_id_stage_fetch_stats.sv - fetch/bubble event counters for the IF/ID register
// Instantiated by if_id_stage only when FETCH_STATS_EN is defined.
module fetch_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic        load_bubble,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (load_valid)  fetch_count_d  = fetch_count_q + 32'd1;
    if (load_bubble) bubble_count_d = bubble_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q  <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC register, fetch FSM and IF/ID pipeline register
// FETCH_STATS_EN adds fetchCount/bubbleCount outputs via fetch_stats.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic [31:0] instrOut,
  output logic [31:0] pcPlus4Out,
  output logic        validOut,
  output logic        halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] bubbleCount
`endif
);

  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = {redirectTarget[PC_W-1:2], 2'b00};
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = RUN;
        end
        RUN: begin
          // A halt word is swallowed as a bubble and the PC parks on it.
          if (!stall) begin
            if (imemData == HALT_WORD) begin
              instr_d = NOP_WORD;
              valid_d = 1'b0;
              state_d = HALT;
            end else begin
              pc_d    = pc_plus4;
              instr_d = imemData;
              pcp4_d  = pc_plus4;
              valid_d = 1'b1;
            end
          end
        end
        HALT: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
        default: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = BOOT;
        end
      endcase
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC_ALIGNED;
      instr_q  <= NOP_WORD;
      pcp4_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcp4_q   <= pcp4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imemAddr   = pc_q;
  assign instrOut   = instr_q;
  assign pcPlus4Out = pcp4_q;
  assign validOut   = valid_q;
  assign halted     = halted_q;

`ifdef FETCH_STATS_EN
  // Every edge loads the IF/ID register except a stall in RUN.
  logic stat_load;
  assign stat_load = redirect || (state_q != RUN) || !stall;

  fetch_stats u_fetch_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (stat_load && valid_d),
    .load_bubble  (stat_load && !valid_d),
    .fetch_count  (fetchCount),
    .bubble_count (bubbleCount)
  );
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed vector table plus randomized model check of if_id_stage
module tb_if_id_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect;
  logic [31:0] redirectTarget, imemAddr, imemData, instrOut, pcPlus4Out;
  logic        validOut, halted;

  logic        w_stall, w_redirect;
  logic [31:0] w_target, w_addr, w_data, w_instr, w_pcp4;
  logic        w_valid, w_halted;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt, bubble_cnt, w_fetch_cnt, w_bubble_cnt;
`endif

  logic [31:0] mem [0:63];

  assign imemData = (imemAddr[31:8] == 24'd0) ? mem[imemAddr[7:2]] : (imemAddr ^ 32'hA5A5_0000);
  assign w_data   = (w_addr[31:8] == 24'd0) ? mem[w_addr[7:2]] : (w_addr ^ 32'hA5A5_0000);

  if_id_stage u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imemAddr       (imemAddr),
    .imemData       (imemData),
    .stall          (stall),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .instrOut       (instrOut),
    .pcPlus4Out     (pcPlus4Out),
    .validOut       (validOut),
    .halted         (halted)
`ifdef FETCH_STATS_EN
    ,
    .fetchCount     (fetch_cnt),
    .bubbleCount    (bubble_cnt)
`endif
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imemAddr       (w_addr),
    .imemData       (w_data),
    .stall          (w_stall),
    .redirect       (w_redirect),
    .redirectTarget (w_target),
    .instrOut       (w_instr),
    .pcPlus4Out     (w_pcp4),
    .validOut       (w_valid),
    .halted         (w_halted)
`ifdef FETCH_STATS_EN
    ,
    .fetchCount     (w_fetch_cnt),
    .bubbleCount    (w_bubble_cnt)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic        halt;
  } vec_t;

  vec_t vt [16];

  // Reference model state: fetch mode 0=boot, 1=running, 2=halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a < 32'h100) return mem[a / 4];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] tgt);
    logic [31:0] word;
    word = mem_model(m_pc);
    if (rd) begin
      m_pc = tgt - (tgt % 4); m_instr = 0; m_valid = 0; m_mode = 1;
    end else if (m_mode == 0) begin
      m_instr = 0; m_valid = 0; m_mode = 1;
    end else if (m_mode == 2) begin
      m_instr = 0; m_valid = 0;
    end else if (!st) begin
      if (word == 32'hFFFF_FFFF) begin
        m_instr = 0; m_valid = 0; m_mode = 2;
      end else begin
        m_instr = word; m_pcp4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirectTarget = '0;
    w_stall = 1'b0; w_redirect = 1'b0; w_target = '0;
    for (int i = 0; i < 64; i++) mem[i] = i + 1;
    mem[4] = 32'hFFFF_FFFF;

    vt[0]  = '{1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0,  1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,  32'h4,  32'h1,  32'h4,  1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,  32'h8,  32'h2,  32'h8,  1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h0,  32'h8,  32'h2,  32'h8,  1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 32'h0,  32'h8,  32'h2,  32'h8,  1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 32'h0,  32'h8,  32'h2,  32'h8,  1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 32'h0,  32'hC,  32'h3,  32'hC,  1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 32'h43, 32'h40, 32'h0,  32'hC,  1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 32'h0,  32'h44, 32'd17, 32'h44, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 32'hC,  32'hC,  32'h0,  32'h44, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 32'h0,  32'h10, 32'h4,  32'h10, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 32'h0,  32'h10, 32'h0,  32'h10, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 32'h0,  32'h10, 32'h0,  32'h10, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b0, 32'h0,  32'h10, 32'h0,  32'h10, 1'b0, 1'b1};
    vt[14] = '{1'b0, 1'b1, 32'h0,  32'h0,  32'h0,  32'h10, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b0, 32'h0,  32'h4,  32'h1,  32'h4,  1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_addr", imemAddr, 32'h0);
    check("reset_instr", instrOut, 32'h0);
    check("reset_pcp4", pcPlus4Out, 32'h0);
    check("reset_valid", {31'd0, validOut}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      stall = vt[i].st; redirect = vt[i].rd; redirectTarget = vt[i].tgt;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_addr", i), imemAddr, vt[i].addr);
      check($sformatf("vec%0d_instr", i), instrOut, vt[i].instr);
      check($sformatf("vec%0d_pcp4", i), pcPlus4Out, vt[i].pcp4);
      check($sformatf("vec%0d_valid", i), {31'd0, validOut}, {31'd0, vt[i].valid});
      check($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vt[i].halt});
      if (i == 0) check("wrap_boot_valid", {31'd0, w_valid}, 32'd0);
      if (i == 1) begin
        check("wrap_instr", w_instr, 32'h5A5A_FFFC);
        check("wrap_pcp4", w_pcp4, 32'h0);
        check("wrap_next_addr", w_addr, 32'h0);
        check("wrap_valid", {31'd0, w_valid}, 32'd1);
      end
`ifdef FETCH_STATS_EN
      if (i == 7) begin
        check("fetch_count", fetch_cnt, 32'd3);
        check("bubble_count", bubble_cnt, 32'd2);
      end
`endif
    end

    // Reset asserted mid-cycle while stall and redirect are both active.
    stall = 1'b1; redirect = 1'b1; redirectTarget = 32'h80;
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_addr", imemAddr, 32'h0);
    check("midreset_instr", instrOut, 32'h0);
    check("midreset_pcp4", pcPlus4Out, 32'h0);
    check("midreset_valid", {31'd0, validOut}, 32'd0);
    check("midreset_halted", {31'd0, halted}, 32'd0);
    check("midreset_wrap_addr", w_addr, 32'hFFFF_FFFC);

    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : ($urandom & 32'h7FFF_FFFF);
    @(posedge clk);
    #1;
    stall = 1'b0; redirect = 1'b0;
    rst_n = 1'b1;
    m_mode = 0; m_pc = 0; m_instr = 0; m_pcp4 = 0; m_valid = 0;

    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 9) == 0);
      redirectTarget = $urandom_range(0, 255);
      @(posedge clk);
      model_edge(stall, redirect, redirectTarget);
      #1;
      check($sformatf("rnd%0d_addr", i), imemAddr, m_pc);
      check($sformatf("rnd%0d_instr", i), instrOut, m_instr);
      check($sformatf("rnd%0d_pcp4", i), pcPlus4Out, m_pcp4);
      check($sformatf("rnd%0d_valid", i), {31'd0, validOut}, {31'd0, m_valid});
      check($sformatf("rnd%0d_halted", i), {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
